// File: rtl/tex_mem_arbiter.sv
// tex_mem_arbiter: round-robin, burst-locked share of one burst-read memory port.
// Optional idle-beat watchdog enabled by defining TEX_ARB_TIMEOUT_EN.
module tex_mem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            rsp_last,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [LEN_WIDTH-1:0]            mem_len,
  input  logic                            mem_req_ready,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  input  logic                            mem_rvalid,
  input  logic                            mem_rlast,
  output logic                            mem_rready,
  output logic                            timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t                 state;
  logic [PTR_W-1:0]       rr_ptr;
  logic [PTR_W-1:0]       grant;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   len_q;

  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [LEN_WIDTH-1:0]   win_len;
  logic                   in_data;
  logic                   beat_xfer;
  logic                   tmo_hit;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ))
        sum = sum - (PTR_W+1)'(NUM_REQ);
      cand = sum[PTR_W-1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_len  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign in_data   = (state == DATA);
  assign beat_xfer = in_data && mem_rvalid && mem_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant  <= win_idx;
            addr_q <= win_addr;
            len_q  <= win_len;
            rr_ptr <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            // Zero-length requests are consumed without a memory command.
            if (win_len != '0)
              state <= CMD;
          end
        end
        CMD: begin
          if (mem_req_ready)
            state <= DATA;
        end
        DATA: begin
          if (beat_xfer && mem_rlast)
            state <= IDLE;
          else if (tmo_hit)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TEX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] stall_cnt;
  logic          tmo_err_q;

  assign tmo_hit = in_data && !beat_xfer &&
                   (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= tmo_hit;
      if (!in_data || beat_xfer || tmo_hit)
        stall_cnt <= '0;
      else
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = rst_n && (state == IDLE) && win_found &&
                     (win_idx == PTR_W'(i));
      rsp_valid[i] = in_data && mem_rvalid && (grant == PTR_W'(i));
    end
  end

  assign rsp_data   = in_data ? mem_rdata : '0;
  assign rsp_last   = in_data && mem_rvalid && mem_rlast;
  assign mem_rready = in_data && rsp_ready[grant];
  assign mem_req    = (state == CMD);
  assign mem_addr   = addr_q;
  assign mem_len    = len_q;

endmodule

// File: tb/tb_tex_mem_arbiter.sv
// tb_tex_mem_arbiter: randomized requesters and memory, scoreboard of commands,
// plus directed zero-length and mid-burst reset checks.
module tb_tex_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_data;
  logic [N-1:0]    rsp_valid;
  logic            rsp_last;
  logic [N-1:0]    rsp_ready;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   mem_len;
  logic            mem_req_ready;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rvalid;
  logic            mem_rlast;
  logic            mem_rready;
  logic            timeout_err;

  tex_mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
    .rsp_ready(rsp_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
    .mem_rready(mem_rready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] addr;
    int          len;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit   mon_en   = 1'b0;
  bit   all_mode = 1'b0;
  bit   quiet    = 1'b0;

  // monitor's reference model
  int   m_ptr = 0;
  int   m_phase = 0;
  cmd_t cur;
  int   bidx = 0;

  // memory model
  bit          mm_busy = 1'b0;
  bit          spur = 1'b0;
  logic [31:0] mm_addr;
  int          mm_len = 0;
  int          mm_idx = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_val(logic [31:0] a, int i);
    return (a ^ (32'(i) * 32'h0001_0003)) + 32'(i);
  endfunction

  // one stimulus cycle: observe handshakes at negedge, drive after posedge
  task automatic step();
    logic [N-1:0] cap;
    bit           cmd_hs;
    bit           beat_hs;
    int           r;
    @(negedge clk);
    cap     = req_valid & req_ready;
    cmd_hs  = mem_req && mem_req_ready;
    beat_hs = mem_rvalid && mem_rready;
    for (int p = 0; p < N; p++) begin
      if (cap[p] && req_len[p*LW +: LW] != '0)
        exp_q.push_back('{p, req_addr[p*AW +: AW], int'(req_len[p*LW +: LW])});
    end
    if (cmd_hs) begin
      mm_busy = 1'b1;
      mm_addr = mem_addr;
      mm_len  = int'(mem_len);
      mm_idx  = 0;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (cap[p]) begin
        req_valid[p] = 1'b0;
      end else if (!req_valid[p]) begin
        if (!quiet && (all_mode || $urandom_range(0, 3) == 0)) begin
          req_valid[p] = 1'b1;
          req_addr[p*AW +: AW] = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
          r = $urandom_range(0, 9);
          req_len[p*LW +: LW] = all_mode ? LW'(4) :
                                (r == 0) ? '0 : LW'($urandom_range(1, 6));
        end
      end else if (!all_mode && $urandom_range(0, 63) == 0) begin
        req_valid[p] = 1'b0;
      end
      rsp_ready[p] = ($urandom_range(0, 3) != 0);
    end
    mem_req_ready = $urandom_range(0, 1);
    if (beat_hs) begin
      mm_idx++;
      if (mm_idx == mm_len)
        mm_busy = 1'b0;
    end
    if (mm_busy) begin
      if (beat_hs || !mem_rvalid || spur) begin
        spur = 1'b0;
        if ($urandom_range(0, 9) < 7) begin
          mem_rvalid = 1'b1;
          mem_rdata  = beat_val(mm_addr, mm_idx);
          mem_rlast  = (mm_idx == mm_len - 1);
        end else begin
          mem_rvalid = 1'b0;
          mem_rlast  = 1'b0;
          mem_rdata  = $urandom;
        end
      end
    end else begin
      // stray beats while no burst is open must be ignored
      spur       = ($urandom_range(0, 7) == 0);
      mem_rvalid = spur;
      mem_rlast  = spur;
      mem_rdata  = $urandom;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_v;
    int           w;
    if (mon_en) begin
      exp_rdy = '0;
      w = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("mem_req", mem_req, m_phase == 1);
      chk("timeout_err", timeout_err, 0);
      exp_v = '0;
      if (m_phase == 2 && mem_rvalid) exp_v[cur.port] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_v);
      chk("mem_rready", mem_rready, (m_phase == 2) && rsp_ready[cur.port]);
      if (m_phase == 0 && w >= 0) begin
        m_ptr = (w + 1) % N;
        if (req_len[w*LW +: LW] != '0) m_phase = 1;
      end else if (m_phase == 1 && mem_req_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard: got command, expected none queued");
        end else begin
          cur = exp_q.pop_front();
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_len", mem_len, cur.len);
          m_phase = 2;
          bidx = 0;
        end
      end else if (m_phase == 2 && mem_rvalid && rsp_ready[cur.port]) begin
        chk("rsp_data", rsp_data, beat_val(cur.addr, bidx));
        chk("rsp_last", rsp_last, bidx == cur.len - 1);
        bidx++;
        if (bidx == cur.len) m_phase = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    req_valid     = '1;
    req_addr      = '0;
    req_len       = '0;
    rsp_ready     = '1;
    mem_req_ready = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    mem_rvalid    = 1'b1;
    mem_rlast     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_last", rsp_last, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_len", mem_len, 0);
    chk("rst mem_rready", mem_rready, 0);
    chk("rst timeout_err", timeout_err, 0);
    req_valid  = '0;
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    rst_n      = 1'b1;
    mon_en     = 1'b1;

    all_mode = 1'b1;
    repeat (150) step();
    all_mode = 1'b0;
    repeat (3000) step();

    quiet = 1'b1;
    done  = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      step();
      done = (req_valid == '0) && (m_phase == 0) && !mm_busy;
    end
    chk("drain", done, 1);
    chk("scoreboard empty", exp_q.size(), 0);
    mon_en = 1'b0;

    // zero-length on port 3, then a burst on port 2 reset mid-DATA
    mem_rvalid    = 1'b0;
    mem_rlast     = 1'b0;
    mem_req_ready = 1'b1;
    rsp_ready     = '1;
    req_valid     = 4'b1000;
    req_len[3*LW +: LW] = '0;
    @(negedge clk);
    chk("len0 req_ready", req_ready, 4'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("len0 mem_req", mem_req, 0);
    end
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 32'h2000;
    req_len[2*LW +: LW]  = LW'(8);
    @(negedge clk);
    chk("burst req_ready", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("burst mem_req", mem_req, 1);
    chk("burst mem_addr", mem_addr, 32'h2000);
    chk("burst mem_len", mem_len, 8);
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_0001;
    req_valid  = '1;
    @(negedge clk);
    chk("burst rsp_valid", rsp_valid, 4'b0100);
    chk("burst rsp_data", rsp_data, 32'hCAFE_0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst rsp_valid", rsp_valid, 0);
    chk("arst mem_rready", mem_rready, 0);
    chk("arst rsp_data", rsp_data, 0);
    chk("arst req_ready", req_ready, 0);
    chk("arst mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst grant", req_ready, 4'b0001);
    chk("post-rst mem_req", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
